// File: rtl/load_store_unit.sv
// load_store_unit: memory stage issuing one load/store at a time to data memory,
// returning load data to the register file and flagging misalignment/timeout.
package simple_processor_pkg;
    localparam int ADDR_WIDTH = 16;
    localparam int DATA_WIDTH = 16;
endpackage

module load_store_unit #(
    parameter int MEM_ADDR_WIDTH = simple_processor_pkg::ADDR_WIDTH,
    parameter int MEM_DATA_WIDTH = simple_processor_pkg::DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      clk_i,
    input  logic                      arst_ni,
    input  logic                      lsu_valid_i,
    output logic                      lsu_ready_o,
    input  logic                      lsu_we_i,
    input  logic [MEM_ADDR_WIDTH-1:0] lsu_addr_i,
    input  logic [MEM_DATA_WIDTH-1:0] lsu_wdata_i,
    input  logic [2:0]                lsu_rd_addr_i,
    output logic                      dmem_req_o,
    output logic                      dmem_we_o,
    output logic [MEM_ADDR_WIDTH-1:0] dmem_addr_o,
    output logic [MEM_DATA_WIDTH-1:0] dmem_wdata_o,
    input  logic [MEM_DATA_WIDTH-1:0] dmem_rdata_i,
    input  logic                      dmem_ack_i,
    output logic                      wb_valid_o,
    output logic [2:0]                wb_rd_addr_o,
    output logic [MEM_DATA_WIDTH-1:0] wb_data_o,
    output logic                      err_o,
    output logic [1:0]                err_code_o
);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e                    state_q, state_d;
    logic                      req_q, req_d, we_q, we_d;
    logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [MEM_DATA_WIDTH-1:0] wdata_q, wdata_d, wb_data_q, wb_data_d;
    logic [2:0]                rd_q, rd_d, wb_rd_q, wb_rd_d;
    logic                      wb_valid_q, wb_valid_d, err_q, err_d;
    logic [1:0]                err_code_q, err_code_d;
    logic [CW-1:0]             cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            err_q      <= 1'b0;
            err_code_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        wb_valid_d = 1'b0;
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        cnt_d      = cnt_q;
        if (state_q == IDLE) begin
            if (lsu_valid_i && lsu_addr_i[0]) begin
                err_d      = 1'b1;
                err_code_d = 2'b01;
            end else if (lsu_valid_i) begin
                state_d = BUSY;
                req_d   = 1'b1;
                we_d    = lsu_we_i;
                addr_d  = lsu_addr_i;
                wdata_d = lsu_wdata_i;
                rd_d    = lsu_rd_addr_i;
                cnt_d   = '0;
            end
        end else if (dmem_ack_i) begin
            // ack beats a timeout expiring in the same cycle
            state_d = IDLE;
            req_d   = 1'b0;
            we_d    = 1'b0;
            if (!we_q) begin
                wb_valid_d = 1'b1;
                wb_data_d  = dmem_rdata_i;
                wb_rd_d    = rd_q;
            end
        end else if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_MAX) begin
            state_d    = IDLE;
            req_d      = 1'b0;
            we_d       = 1'b0;
            err_d      = 1'b1;
            err_code_d = 2'b10;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign lsu_ready_o  = (state_q == IDLE);
    assign dmem_req_o   = req_q;
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_wdata_o = wdata_q;
    assign wb_valid_o   = wb_valid_q;
    assign wb_data_o    = wb_data_q;
    assign wb_rd_addr_o = wb_rd_q;
    assign err_o        = err_q;
    assign err_code_o   = err_code_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vector table plus hand sequences for back-to-back and reset.
module tb_load_store_unit;
    logic        clk_i = 1'b0, arst_ni = 1'b0;
    logic        lsu_valid_i = 1'b0, lsu_we_i = 1'b0, dmem_ack_i = 1'b0;
    logic [15:0] lsu_addr_i = '0, lsu_wdata_i = '0, dmem_rdata_i = '0;
    logic [2:0]  lsu_rd_addr_i = '0;
    logic        lsu_ready_o, dmem_req_o, dmem_we_o, wb_valid_o, err_o;
    logic [15:0] dmem_addr_o, dmem_wdata_o, wb_data_o;
    logic [2:0]  wb_rd_addr_o;
    logic [1:0]  err_code_o;
    int          total = 0, passed = 0;

    load_store_unit #(.MEM_ADDR_WIDTH(16), .MEM_DATA_WIDTH(16), .TIMEOUT_CYCLES(4)) dut (
        .clk_i(clk_i), .arst_ni(arst_ni),
        .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o), .lsu_we_i(lsu_we_i),
        .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_rd_addr_i(lsu_rd_addr_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_rdata_i(dmem_rdata_i), .dmem_ack_i(dmem_ack_i),
        .wb_valid_o(wb_valid_o), .wb_rd_addr_o(wb_rd_addr_o), .wb_data_o(wb_data_o),
        .err_o(err_o), .err_code_o(err_code_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [2:0]  rd;
        int          ackd;
        logic [15:0] rdata;
        int          exp_req;
        int          exp_wb;
        int          exp_err;
        logic [1:0]  exp_code;
        int          exp_ready;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    task automatic run_vec(input vec_t v);
        int reqn = 0, wbn = 0, errn = 0, ready_at = -1, bad = 0;
        logic [1:0]  code = '0;
        logic [15:0] wbd = '0;
        logic [2:0]  wbrd = '0;
        @(negedge clk_i);
        chk({v.name, " ready_idle"}, 32'(lsu_ready_o), 1);
        lsu_valid_i = 1'b1; lsu_we_i = v.we; lsu_addr_i = v.addr;
        lsu_wdata_i = v.wdata; lsu_rd_addr_i = v.rd;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk_i);
            if (c == 0) lsu_valid_i = 1'b0;
            if (dmem_req_o) begin
                if (dmem_addr_o !== v.addr || dmem_we_o !== v.we || dmem_wdata_o !== v.wdata) bad++;
                dmem_ack_i   = (reqn == v.ackd);
                dmem_rdata_i = dmem_ack_i ? v.rdata : 16'hDEAD;
                reqn++;
            end else begin
                dmem_ack_i   = 1'b1;
                dmem_rdata_i = 16'hDEAD;
            end
            if (wb_valid_o) begin wbn++; wbd = wb_data_o; wbrd = wb_rd_addr_o; end
            if (err_o) begin errn++; code = err_code_o; end
            if (ready_at < 0 && lsu_ready_o) ready_at = c;
        end
        dmem_ack_i = 1'b0;
        chk({v.name, " req_cycles"}, 32'(reqn), 32'(v.exp_req));
        chk({v.name, " bus_stable"}, 32'(bad), 0);
        chk({v.name, " wb_pulses"}, 32'(wbn), 32'(v.exp_wb));
        chk({v.name, " err_pulses"}, 32'(errn), 32'(v.exp_err));
        chk({v.name, " ready_at"}, 32'(ready_at), 32'(v.exp_ready));
        if (v.exp_err != 0) chk({v.name, " err_code"}, 32'(code), 32'(v.exp_code));
        if (v.exp_wb != 0) begin
            chk({v.name, " wb_data"}, 32'(wbd), 32'(v.rdata));
            chk({v.name, " wb_rd"}, 32'(wbrd), 32'(v.rd));
        end
    endtask

    initial begin
        vec_t vecs[7];
        logic [7:0] req_log, wb_log;
        logic [15:0] wb_d[2];
        logic [2:0]  wb_r[2];
        int run, accepts, wbn, nreq, nwb, nerr, bad;
        vecs[0] = '{"load_wait3",   1'b0, 16'h0010, 16'h0000, 3'd5, 2,  16'hBEEF, 3, 1, 0, 2'b00, 3};
        vecs[1] = '{"store_zw",     1'b1, 16'h0020, 16'h1234, 3'd0, 0,  16'h0000, 1, 0, 0, 2'b00, 1};
        vecs[2] = '{"misalign_ld",  1'b0, 16'h0021, 16'h0000, 3'd4, -1, 16'h0000, 0, 0, 1, 2'b01, 0};
        vecs[3] = '{"timeout_ld",   1'b0, 16'h0040, 16'h0000, 3'd6, -1, 16'h0000, 4, 0, 1, 2'b10, 4};
        vecs[4] = '{"ack_at_limit", 1'b0, 16'h0042, 16'h0000, 3'd7, 3,  16'h5A5A, 4, 1, 0, 2'b00, 4};
        vecs[5] = '{"misalign_st",  1'b1, 16'h0003, 16'h7777, 3'd0, -1, 16'h0000, 0, 0, 1, 2'b01, 0};
        vecs[6] = '{"load_zw",      1'b0, 16'h0100, 16'h0000, 3'd1, 0,  16'hCAFE, 1, 1, 0, 2'b00, 1};

        #2;
        chk("rst ready", 32'(lsu_ready_o), 1);
        chk("rst outs", {dmem_req_o, dmem_we_o, wb_valid_o, err_o, err_code_o, wb_rd_addr_o}, 0);
        chk("rst buses", {dmem_addr_o, dmem_wdata_o}, 0);
        @(negedge clk_i); @(negedge clk_i);
        arst_ni = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // back-to-back loads, second command held valid through the first's BUSY
        @(negedge clk_i);
        lsu_valid_i = 1'b1; lsu_we_i = 1'b0; lsu_addr_i = 16'h0002; lsu_rd_addr_i = 3'd2;
        req_log = '0; wb_log = '0; run = 0; accepts = 1; wbn = 0; bad = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_i);
            if (c == 0) begin lsu_addr_i = 16'h0004; lsu_rd_addr_i = 3'd3; end
            if (accepts == 2) lsu_valid_i = 1'b0;
            req_log[c] = dmem_req_o;
            if (dmem_req_o) begin
                if (dmem_addr_o !== ((accepts == 1) ? 16'h0002 : 16'h0004)) bad++;
                dmem_ack_i = (run == 1);
                dmem_rdata_i = (accepts == 1) ? 16'h1111 : 16'h2222;
                run++;
            end else begin
                dmem_ack_i = 1'b0;
                run = 0;
            end
            wb_log[c] = wb_valid_o;
            if (wb_valid_o && wbn < 2) begin wb_d[wbn] = wb_data_o; wb_r[wbn] = wb_rd_addr_o; wbn++; end
            if (lsu_ready_o && lsu_valid_i) accepts++;
        end
        dmem_ack_i = 1'b0; lsu_valid_i = 1'b0;
        chk("b2b req_pattern", 32'(req_log), 32'h1B);
        chk("b2b wb_pattern", 32'(wb_log), 32'h24);
        chk("b2b addr", 32'(bad), 0);
        chk("b2b wb0", {13'd0, wb_r[0], wb_d[0]}, {13'd0, 3'd2, 16'h1111});
        chk("b2b wb1", {13'd0, wb_r[1], wb_d[1]}, {13'd0, 3'd3, 16'h2222});

        // reset in the middle of a store
        @(negedge clk_i);
        lsu_valid_i = 1'b1; lsu_we_i = 1'b1; lsu_addr_i = 16'h0030; lsu_wdata_i = 16'hA5A5;
        @(negedge clk_i);
        lsu_valid_i = 1'b0;
        chk("rst_mid req_before", {dmem_req_o, dmem_we_o, dmem_wdata_o}, {1'b1, 1'b1, 16'hA5A5});
        @(negedge clk_i);
        #2 arst_ni = 1'b0;
        #1;
        chk("rst_mid req_drop", {dmem_req_o, dmem_we_o, lsu_ready_o}, 3'b001);
        chk("rst_mid buses", {dmem_addr_o, dmem_wdata_o, wb_data_o}, 0);
        chk("rst_mid flags", {wb_valid_o, err_o, err_code_o, wb_rd_addr_o}, 0);
        @(negedge clk_i);
        arst_ni = 1'b1;
        nreq = 0; nwb = 0; nerr = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            nreq += int'(dmem_req_o); nwb += int'(wb_valid_o); nerr += int'(err_o);
        end
        chk("rst_mid quiet", 32'(nreq + nwb + nerr), 0);
        chk("rst_mid ready", 32'(lsu_ready_o), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory stage of the simple processor.
- Sits downstream of the execution block and upstream of the register-file write port.
- Accepts one load/store command at a time and drives the data-memory request/acknowledge interface.
- Returns load data to the register file and signals busy so the PC/decoder can stall.

Parameters:
- MEM_ADDR_WIDTH, default simple_processor_pkg::ADDR_WIDTH: data address bus width.
- MEM_DATA_WIDTH, default simple_processor_pkg::DATA_WIDTH: data bus width.
- TIMEOUT_CYCLES, default 16: maximum request cycles without ack before abort. 0 disables the timeout.

Ports:
- clk_i  in  1  global clock, rising edge.
- arst_ni  in  1  asynchronous, active-low reset.
- lsu_valid_i  in  1  command valid from decode/execute.
- lsu_ready_o  out  1  unit can accept a command this cycle.
- lsu_we_i  in  1  1 = store, 0 = load.
- lsu_addr_i  in  MEM_ADDR_WIDTH  effective byte address (base + imm).
- lsu_wdata_i  in  MEM_DATA_WIDTH  store data.
- lsu_rd_addr_i  in  3  load destination register.
- dmem_req_o  out  1  memory request active.
- dmem_we_o  out  1  write request.
- dmem_addr_o  out  MEM_ADDR_WIDTH  memory address.
- dmem_wdata_o  out  MEM_DATA_WIDTH  memory write data.
- dmem_rdata_i  in  MEM_DATA_WIDTH  memory read data, valid when ack is high.
- dmem_ack_i  in  1  request completed.
- wb_valid_o  out  1  one-cycle pulse, load data valid.
- wb_rd_addr_o  out  3  writeback register.
- wb_data_o  out  MEM_DATA_WIDTH  writeback data.
- err_o  out  1  one-cycle error pulse.
- err_code_o  out  2  error cause: 01 misaligned, 10 timeout, 00 none.

Behaviour:
- Clock and reset: clk_i is the clock; arst_ni is an asynchronous, active-low reset.
- Reset values:
  - State = IDLE.
  - dmem_req_o, dmem_we_o, wb_valid_o, err_o = 0.
  - dmem_addr_o, dmem_wdata_o, wb_data_o, wb_rd_addr_o, err_code_o = 0.
  - Timeout counter = 0.
  - lsu_ready_o = 1 during and after reset.
- All outputs except lsu_ready_o are registered. lsu_ready_o = (state == IDLE).
- FSM states: IDLE, BUSY.
- IDLE, lsu_valid_i = 1, lsu_addr_i[0] = 0:
  - Latch addr, we, wdata, rd_addr.
  - Next cycle: dmem_req_o = 1, state BUSY, counter cleared.
- IDLE, lsu_valid_i = 1, lsu_addr_i[0] = 1 (misaligned):
  - No memory request.
  - Next cycle: err_o = 1, err_code_o = 01. State stays IDLE.
- BUSY:
  - dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o are held stable until the cycle in which dmem_ack_i is sampled high.
  - Counter increments each cycle without ack.
- BUSY with dmem_ack_i = 1:
  - Next cycle: dmem_req_o = 0, state IDLE.
  - Load: wb_valid_o = 1 for one cycle, wb_data_o = dmem_rdata_i sampled at ack, wb_rd_addr_o = latched rd.
  - Store: no wb_valid_o.
- BUSY, no ack, counter == TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES != 0):
  - Next cycle: req = 0, err_o = 1, err_code_o = 10, state IDLE, no writeback.
- Ack in the same cycle as timeout expiry: ack wins; normal completion, no error.
- Latency: command accepted at T, req high at T+1. Ack at T+k gives wb_valid_o / ready at T+k+1. Zero-wait ack (k = 1) gives 2-cycle total latency.
- Back-to-back: a new command may be accepted in the cycle ready returns high (T+k+1). Its req rises at T+k+2; req is low for at least one cycle between transactions.
- lsu_valid_i while BUSY is ignored. The upstream stage must hold it until lsu_ready_o = 1.
- dmem_ack_i in IDLE is ignored.
- wb_data_o and wb_rd_addr_o hold their last values when wb_valid_o = 0.
- err_code_o holds its last value; err_o is the qualifier.
- Reset asserted mid-transaction: immediate return to reset values, req drops asynchronously, no writeback or error is issued.

Test Plan:
- Load, addr 0x0010, ack 3 cycles after req, rdata 0xBEEF, rd 5 -> req high for exactly 3 cycles with addr 0x0010, we 0; one cycle later wb_valid_o = 1, wb_data_o = 0xBEEF, wb_rd_addr_o = 5.
- Store, addr 0x0020, wdata 0x1234, ack in the first req cycle -> one req cycle with we 1, wdata 0x1234; no wb_valid_o; ready high 2 cycles after accept.
- Misaligned load, addr 0x0021 -> dmem_req_o never asserts; err_o pulse with err_code_o = 01 one cycle later; ready stays 1.
- TIMEOUT_CYCLES = 4, load with no ack -> req high exactly 4 cycles, then err_o = 1 with code 10, no wb_valid_o. Repeat with ack on the 4th cycle -> normal completion, no error.
- Two loads back-to-back (addr 0x0002 then 0x0004, ack after 1 cycle each) -> second req rises 1 cycle after the first drops; two wb pulses with correct data/rd; extra lsu_valid_i during BUSY is ignored.
- arst_ni low during BUSY of a store -> req drops immediately, all outputs at reset values, no error or writeback after release.
